i2c_controller: RTL and testbench



---
 rtl/i2c_controller.sv | 96 +++++++++
 tb/tb_i2c_controller.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_controller.sv
// Write-only single-master I2C transmitter: sends one 3-byte frame (address, sub-address, data)
// and reports the three acknowledge slots. SCL is push-pull, SDA is open-drain.
module i2c_controller (
  input  logic        CLOCK,
  input  logic        RESET_N,
  output logic        I2C_SCLK,
  inout  wire         I2C_SDAT,
  input  logic [23:0] I2C_DATA,
  input  logic        GO,
  output logic        END,
  output logic [2:0]  ACK
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t      r_state;
  logic [5:0]  r_cnt;
  logic [23:0] r_sr;
  logic        r_scl;
  logic        r_sda_lo;
  logic        r_end;
  logic [2:0]  r_ack;

  logic w_sda_in;
  logic w_ack_slot;

  assign I2C_SDAT   = r_sda_lo ? 1'b0 : 1'bz;
  assign w_sda_in   = I2C_SDAT;
  assign I2C_SCLK   = r_scl;
  assign END        = r_end;
  assign ACK        = r_ack;

  // r_cnt is the index of the edge being processed; odd edges 17/35/53 open the ack slots.
  assign w_ack_slot = (r_cnt == 6'd17) || (r_cnt == 6'd35) || (r_cnt == 6'd53);

  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      r_state  <= S_DONE;
      r_cnt    <= 6'd0;
      r_scl    <= 1'b1;
      r_sda_lo <= 1'b0;
      r_end    <= 1'b1;
      r_ack    <= 3'b000;
    end else if (!GO) begin
      r_state  <= S_IDLE;
      r_cnt    <= 6'd0;
      r_scl    <= 1'b1;
      r_sda_lo <= 1'b0;
      r_end    <= 1'b0;
      r_ack    <= 3'b000;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_sr     <= I2C_DATA;
          r_scl    <= 1'b1;
          r_sda_lo <= 1'b1;
          r_cnt    <= 6'd1;
          r_state  <= S_RUN;
        end
        S_RUN: begin
          r_cnt <= r_cnt + 6'd1;
          if (r_cnt <= 6'd54) begin
            r_scl <= ~r_cnt[0];
            if (r_cnt[0]) begin
              if (w_ack_slot) begin
                r_sda_lo <= 1'b0;
              end else begin
                r_sda_lo <= ~r_sr[23];
                r_sr     <= {r_sr[22:0], 1'b0};
              end
            end
          end else if (r_cnt == 6'd55) begin
            r_scl    <= 1'b0;
            r_sda_lo <= 1'b1;
          end else if (r_cnt == 6'd56) begin
            r_scl    <= 1'b1;
          end else if (r_cnt == 6'd57) begin
            r_sda_lo <= 1'b0;
          end else begin
            r_end   <= 1'b1;
            r_state <= S_DONE;
          end
          // Ack is read on the edge that drops SCL after the ack slot's high phase.
          if (r_cnt == 6'd19) r_ack[2] <= w_sda_in;
          if (r_cnt == 6'd37) r_ack[1] <= w_sda_in;
          if (r_cnt == 6'd55) r_ack[0] <= w_sda_in;
        end
        default: begin
          r_scl    <= 1'b1;
          r_sda_lo <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_controller.sv
// Bench for i2c_controller: bus monitor/slave model decodes frames, a scoreboard queue holds
// the bytes expected on the wire, and a vector table drives back-to-back frames.
module tb_i2c_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        go;
  logic [23:0] data;
  logic        scl;
  logic        end_o;
  logic [2:0]  ack;
  wire         sda_bus;
  logic        slave_lo = 1'b0;
  logic [2:0]  slave_en = 3'b000;

  always #5 clk = ~clk;

  assign sda_bus = slave_lo ? 1'b0 : 1'bz;
  pullup (sda_bus);

  i2c_controller dut (
    .CLOCK   (clk),
    .RESET_N (rst_n),
    .I2C_SCLK(scl),
    .I2C_SDAT(sda_bus),
    .I2C_DATA(data),
    .GO      (go),
    .END     (end_o),
    .ACK     (ack)
  );

  // Bus monitor and slave model
  logic       prev_scl = 1'b1;
  logic       prev_sda = 1'b1;
  logic       in_frame = 1'b0;
  int         bitcnt   = 0;
  int         byteidx  = 0;
  logic [7:0] shreg    = 8'h00;
  logic [7:0] obs_byte [0:255];
  int         obs_n    = 0;
  int         n_start  = 0;
  int         n_stop   = 0;

  always @(negedge clk) begin
    logic sda_v;
    sda_v = (sda_bus === 1'b0) ? 1'b0 : 1'b1;
    if (scl && prev_scl && prev_sda && !sda_v) begin
      n_start++;
      in_frame = 1'b1;
      bitcnt   = 0;
      byteidx  = 0;
      slave_lo = 1'b0;
    end else if (scl && prev_scl && !prev_sda && sda_v) begin
      n_stop++;
      in_frame = 1'b0;
      slave_lo = 1'b0;
    end else if (in_frame && scl && !prev_scl) begin
      if (bitcnt < 8) begin
        shreg  = {shreg[6:0], sda_v};
        bitcnt = bitcnt + 1;
      end else begin
        if (obs_n < 256) obs_byte[obs_n] = shreg;
        obs_n++;
        byteidx++;
        bitcnt = 0;
      end
    end else if (in_frame && !scl && prev_scl) begin
      slave_lo = (bitcnt == 8) && (byteidx < 3) && slave_en[2 - byteidx];
    end
    prev_scl = scl;
    prev_sda = sda_v;
  end

  // Scoreboard and checks
  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_q [$];
  int         rd    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic run_frame(input logic [23:0] d, input logic [2:0] slv,
                           input logic [2:0] exp_ack, input int chg_at);
    int s0, p0, lat;
    go = 1'b0;
    @(posedge clk); #1;
    chk("idle_end", {31'd0, end_o}, 32'd0);
    slave_en = slv;
    data     = d;
    go       = 1'b1;
    s0 = n_start;
    p0 = n_stop;
    rd = obs_n;
    exp_q.push_back(d[23:16]);
    exp_q.push_back(d[15:8]);
    exp_q.push_back(d[7:0]);
    lat = -1;
    for (int k = 0; k < 70; k++) begin
      @(posedge clk); #1;
      if (k == chg_at) data = 24'hFFFFFF;
      if (end_o) begin
        lat = k;
        break;
      end
    end
    chk("latency", lat, 32'd58);
    chk("ack", {29'd0, ack}, {29'd0, exp_ack});
    chk("starts", n_start - s0, 32'd1);
    chk("stops", n_stop - p0, 32'd1);
    for (int b = 0; b < 3; b++) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      if (rd < obs_n) begin
        chk("byte", {24'd0, obs_byte[rd % 256]}, {24'd0, e});
        rd++;
      end else begin
        chk("byte_missing", {24'd0, 8'h00}, {24'd0, e} | 32'h100);
      end
    end
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    chk("end_hold", {29'd0, end_o, scl, sda_bus === 1'b1}, 32'd7);
    chk("ack_hold", {29'd0, ack}, {29'd0, exp_ack});
  endtask

  typedef struct {
    logic [23:0] d;
    logic [2:0]  slv;
    logic [2:0]  exp_ack;
  } vec_t;

  vec_t tbl [9];

  initial begin
    int s0;
    tbl[0] = '{24'h341E00, 3'b111, 3'b000};
    tbl[1] = '{24'h341E00, 3'b000, 3'b111};
    tbl[2] = '{24'h341E00, 3'b100, 3'b011};
    tbl[3] = '{24'h341E79, 3'b111, 3'b000};
    tbl[4] = '{24'h340C55, 3'b110, 3'b001};
    tbl[5] = '{24'h3402AA, 3'b011, 3'b100};
    tbl[6] = '{24'h34FF01, 3'b101, 3'b010};
    tbl[7] = '{24'h000000, 3'b111, 3'b000};
    tbl[8] = '{24'hFFFFFF, 3'b001, 3'b110};

    // Reset with GO already high
    rst_n = 1'b0;
    go    = 1'b1;
    data  = 24'h123456;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_scl", {31'd0, scl}, 32'd1);
    chk("rst_sda", {31'd0, sda_bus === 1'b1}, 32'd1);
    chk("rst_end", {31'd0, end_o}, 32'd1);
    chk("rst_ack", {29'd0, ack}, 32'd0);
    rst_n = 1'b1;
    s0 = n_start;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("rst_go_quiet", {30'd0, scl, end_o}, 32'd3);
    end
    chk("rst_no_start", n_start - s0, 32'd0);
    go = 1'b0;
    @(posedge clk); #1;
    chk("rst_drop_end", {31'd0, end_o}, 32'd0);
    chk("rst_drop_ack", {29'd0, ack}, 32'd0);

    // Back-to-back config-style frames
    for (int v = 0; v < 9; v++)
      run_frame(tbl[v].d, tbl[v].slv, tbl[v].exp_ack, -1);

    // Data change after E0 must not reach the bus
    run_frame(24'h341E79, 3'b111, 3'b000, 5);

    // Abort at E20
    go = 1'b0;
    @(posedge clk); #1;
    data     = 24'h341E00;
    slave_en = 3'b000;
    go       = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (k == 18) chk("abort_ack_pre", {29'd0, ack}, 32'd0);
      if (k == 19) begin
        chk("abort_ack_e19", {29'd0, ack}, 32'd4);
        go = 1'b0;
      end
    end
    @(posedge clk); #1;
    chk("abort_scl", {31'd0, scl}, 32'd1);
    chk("abort_sda", {31'd0, sda_bus === 1'b1}, 32'd1);
    chk("abort_end", {31'd0, end_o}, 32'd0);
    chk("abort_ack", {29'd0, ack}, 32'd0);
    run_frame(24'h5A0F3C, 3'b111, 3'b000, -1);

    // Reset in the middle of a frame
    go = 1'b0;
    @(posedge clk); #1;
    data     = 24'h341E00;
    slave_en = 3'b111;
    go       = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (k == 29) rst_n = 1'b0;
    end
    @(posedge clk); #1;
    chk("midrst_state", {28'd0, end_o, scl, sda_bus === 1'b1, 1'b0}, 32'hE);
    chk("midrst_ack", {29'd0, ack}, 32'd0);
    rst_n = 1'b1;
    s0 = n_start;
    repeat (5) @(posedge clk);
    #1;
    chk("midrst_quiet", {30'd0, scl, end_o}, 32'd3);
    chk("midrst_no_start", n_start - s0, 32'd0);
    run_frame(24'h34A5C3, 3'b010, 3'b101, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
